banked_regfile_v2: RTL and testbench

//  Parametrised banked CPU register file: NUM_BANKS banks of 8 GPRs (addr 0-7), 4 scratch (8-B),
//  ISR (C), read-only SP/SR/PC views (D/E/F). NUM_RD combinational read ports, one write port.

---
 rtl/banked_regfile_v2_if.sv | 35 +++
 rtl/banked_regfile_v2.sv | 146 ++++++++++++++
 tb/tb_banked_regfile_v2.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banked_regfile_v2_if.sv
// Bus interface for banked_regfile_v2: read ports, write port, clear engine, external SP/SR/PC.
interface banked_regfile_v2_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_BANKS = 256,
    parameter int unsigned NUM_RD    = 3
);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [BANK_W-1:0]        bank_sel;
    logic [NUM_RD*4-1:0]      read_addr;
    logic [NUM_RD*DATA_W-1:0] read_data;
    logic [3:0]               write_addr;
    logic [DATA_W-1:0]        write_data;
    logic                     write_en;
    logic                     write_ready;
    logic                     clear_req;
    logic [BANK_W-1:0]        clear_bank;
    logic                     clear_busy;
    logic                     clear_done;
    logic [DATA_W-1:0]        sp;
    logic [DATA_W-1:0]        sr;
    logic [DATA_W-1:0]        pc;

    modport master (
        output bank_sel, read_addr, write_addr, write_data, write_en,
               clear_req, clear_bank, sp, sr, pc,
        input  read_data, write_ready, clear_busy, clear_done
    );

    modport slave (
        input  bank_sel, read_addr, write_addr, write_data, write_en,
               clear_req, clear_bank, sp, sr, pc,
        output read_data, write_ready, clear_busy, clear_done
    );
endinterface

// File: rtl/banked_regfile_v2.sv
// Banked CPU register file: NUM_BANKS x 8 GPRs, 4 scratch, ISR, SP/SR/PC views,
// NUM_RD combinational read ports, one write port and an 8-cycle bank-clear engine.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding on reads).
// reset_n release is expected to be synchronised to clock upstream.
module banked_regfile_v2 #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_BANKS = 256,
    parameter int unsigned NUM_RD    = 3
) (
    input logic                clock,
    input logic                reset_n,
    banked_regfile_v2_if.slave bus
);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned GPR_W  = BANK_W + 3;
    localparam int unsigned DEPTH  = NUM_BANKS * 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_n;
    logic [2:0]          idx, idx_n;
    logic [BANK_W-1:0]   cbank, cbank_n;
    logic                done_n;
    logic                clear_done_q;
    logic                clear_we;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   scratch [4];
    logic [DATA_W-1:0]   isr;

    logic                write_ready_c;
    logic                wr_acc;
    logic                gpr_we, scr_we, isr_we;

    logic [3:0]                ra;
    logic [DATA_W-1:0]         word;
    logic [NUM_RD*DATA_W-1:0]  rd_all;

    // Port writes stall only when they target the bank being cleared.
    assign write_ready_c = !(state == CLEAR && !bus.write_addr[3] && bus.bank_sel == cbank);
    assign wr_acc        = bus.write_en && write_ready_c;
    assign gpr_we        = wr_acc && !bus.write_addr[3];
    assign scr_we        = wr_acc && (bus.write_addr[3:2] == 2'b10);
    assign isr_we        = wr_acc && (bus.write_addr == 4'hC);

    assign bus.write_ready = write_ready_c;
    assign bus.clear_busy  = (state == CLEAR);
    assign bus.clear_done  = clear_done_q;
    assign bus.read_data   = rd_all;

    // Clear engine state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= 3'd0;
            cbank        <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            cbank        <= cbank_n;
            clear_done_q <= done_n;
        end
    end

    // Clear engine next-state: one register zeroed per cycle, done pulses after the 8th.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cbank_n  = cbank;
        done_n   = 1'b0;
        clear_we = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_n = CLEAR;
                    idx_n   = 3'd0;
                    cbank_n = bus.clear_bank;
                end
            end
            CLEAR: begin
                clear_we = 1'b1;
                idx_n    = idx + 3'd1;
                if (idx == 3'd7) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // GPR storage: clear and port write never hit the same bank, so both may fire together.
    always_ff @(posedge clock) begin
        if (clear_we) begin
            mem[GPR_W'({cbank, idx})] <= '0;
        end
        if (gpr_we) begin
            mem[GPR_W'({bus.bank_sel, bus.write_addr[2:0]})] <= bus.write_data;
        end
    end

    // Scratch and ISR registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                scratch[i] <= '0;
            end
            isr <= '0;
        end else begin
            if (scr_we) begin
                scratch[bus.write_addr[1:0]] <= bus.write_data;
            end
            if (isr_we) begin
                isr <= bus.write_data;
            end
        end
    end

    // Independent combinational read ports.
    always_comb begin
        rd_all = '0;
        ra     = 4'h0;
        word   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.read_addr[4*i +: 4];
            case (ra)
                4'h8, 4'h9, 4'hA, 4'hB: word = scratch[ra[1:0]];
                4'hC:                   word = isr;
                4'hD:                   word = bus.sp;
                4'hE:                   word = bus.sr;
                4'hF:                   word = bus.pc;
                default:                word = mem[GPR_W'({bus.bank_sel, ra[2:0]})];
            endcase
`ifdef REGFILE_BYPASS_EN
            if (wr_acc && ra == bus.write_addr && ra <= 4'hC) begin
                word = bus.write_data;
            end
            if (state == CLEAR && !ra[3] && bus.bank_sel == cbank && ra[2:0] == idx) begin
                word = '0;
            end
`endif
            rd_all[DATA_W*i +: DATA_W] = word;
        end
    end
endmodule

// File: tb/tb_banked_regfile_v2.sv
// Self-checking bench for banked_regfile_v2: behavioural model plus directed vectors.
module tb_banked_regfile_v2;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NUM_BANKS = 256;
    localparam int unsigned NUM_RD    = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    banked_regfile_v2_if #(.DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS), .NUM_RD(NUM_RD)) bus ();

    banked_regfile_v2 #(.DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS), .NUM_RD(NUM_RD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit run_cmp  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model of the architectural state.
    logic [DATA_W-1:0] m_bank [NUM_BANKS][8];
    bit                m_known [NUM_BANKS][8];
    logic [DATA_W-1:0] m_scr [4];
    logic [DATA_W-1:0] m_isr;
    bit                m_busy;
    bit                m_done;
    int                m_pos;
    logic [7:0]        m_cbank;

    function automatic bit m_ready();
        return !(m_busy && bus.write_addr < 4'd8 && bus.bank_sel == m_cbank);
    endfunction

    function automatic logic [DATA_W:0] m_read(input logic [3:0] a);
        bit kn = 1'b1;
        logic [DATA_W-1:0] v;
        if (a < 4'd8) begin
            v  = m_bank[bus.bank_sel][a[2:0]];
            kn = m_known[bus.bank_sel][a[2:0]];
        end else if (a < 4'd12) v = m_scr[a[1:0]];
        else if (a == 4'd12)    v = m_isr;
        else if (a == 4'd13)    v = bus.sp;
        else if (a == 4'd14)    v = bus.sr;
        else                    v = bus.pc;
`ifdef REGFILE_BYPASS_EN
        if (bus.write_en && m_ready() && a == bus.write_addr && a <= 4'hC) begin
            v  = bus.write_data;
            kn = 1'b1;
        end
        if (m_busy && a < 4'd8 && bus.bank_sel == m_cbank && int'(a[2:0]) == m_pos) begin
            v  = '0;
            kn = 1'b1;
        end
`endif
        return {kn, v};
    endfunction

    // Model update: clear zeroes one register per cycle; accepted writes update the map.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) m_scr[i] <= '0;
            m_isr  <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_pos  <= 0;
        end else begin
            m_done <= m_busy && m_pos == 7;
            if (m_busy) begin
                m_bank[m_cbank][m_pos]  <= '0;
                m_known[m_cbank][m_pos] <= 1'b1;
                if (m_pos == 7) m_busy <= 1'b0;
                else            m_pos  <= m_pos + 1;
            end else if (bus.clear_req) begin
                m_busy  <= 1'b1;
                m_pos   <= 0;
                m_cbank <= bus.clear_bank;
            end
            if (bus.write_en && m_ready()) begin
                if (bus.write_addr < 4'd8) begin
                    m_bank[bus.bank_sel][bus.write_addr[2:0]]  <= bus.write_data;
                    m_known[bus.bank_sel][bus.write_addr[2:0]] <= 1'b1;
                end else if (bus.write_addr < 4'd12) m_scr[bus.write_addr[1:0]] <= bus.write_data;
                else if (bus.write_addr == 4'd12)    m_isr <= bus.write_data;
            end
        end
    end

    // Every-cycle comparison against the model.
    logic [DATA_W:0] r;
    always @(negedge clock) begin
        if (run_cmp) begin
            for (int i = 0; i < int'(NUM_RD); i++) begin
                r = m_read(bus.read_addr[4*i +: 4]);
                if (r[DATA_W]) check($sformatf("model_rd%0d", i), bus.read_data[DATA_W*i +: DATA_W], r[DATA_W-1:0]);
            end
            check("model_write_ready", bus.write_ready, m_ready());
            check("model_clear_busy", bus.clear_busy, m_busy);
            check("model_clear_done", bus.clear_done, m_done);
        end
    end

    function automatic logic [DATA_W-1:0] rdp(input int i);
        return bus.read_data[DATA_W*i +: DATA_W];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] bank, input logic [3:0] a, input logic [DATA_W-1:0] d);
        bus.bank_sel   = bank;
        bus.write_addr = a;
        bus.write_data = d;
        bus.write_en   = 1'b1;
        tick();
        bus.write_en   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] bank, input logic [3:0] a,
                          input logic [DATA_W-1:0] exp);
        bus.bank_sel       = bank;
        bus.read_addr[3:0] = a;
        @(negedge clock);
        check(name, rdp(0), exp);
        tick();
    endtask

    int n_busy, done_cyc, waits, n_done;
    bit got;

    initial begin
        bus.bank_sel   = '0;
        bus.read_addr  = {4'hA, 4'h9, 4'h8};
        bus.write_addr = 4'h0;
        bus.write_data = '0;
        bus.write_en   = 1'b0;
        bus.clear_req  = 1'b0;
        bus.clear_bank = '0;
        bus.sp         = 16'h0D0D;
        bus.sr         = 16'h5A5A;
        bus.pc         = 16'h0F0F;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        run_cmp = 1'b1;

        // Reset values.
        @(negedge clock);
        check("rst_scr8", rdp(0), 16'h0000);
        check("rst_scr9", rdp(1), 16'h0000);
        check("rst_scrA", rdp(2), 16'h0000);
        check("rst_ready", bus.write_ready, 1'b1);
        tick();
        bus.read_addr = {4'hD, 4'hC, 4'hB};
        @(negedge clock);
        check("rst_scrB", rdp(0), 16'h0000);
        check("rst_isr", rdp(1), 16'h0000);
        check("sp_view", rdp(2), 16'h0D0D);
        check("rst_busy", bus.clear_busy, 1'b0);
        tick();

        // Register map.
        wr(8'd6, 4'h3, 16'h1111);
        wr(8'd5, 4'h3, 16'hBEEF);
        rd_chk("b6_r3", 8'd6, 4'h3, 16'h1111);
        rd_chk("b5_r3", 8'd5, 4'h3, 16'hBEEF);
        wr(8'd5, 4'hE, 16'h1234);
        rd_chk("sr_view", 8'd5, 4'hE, 16'h5A5A);

        // Full clear of bank 9.
        for (int i = 0; i < 8; i++) begin
            wr(8'd9, 4'(i), 16'hA5A0 + 16'(i));
            wr(8'd8, 4'(i), 16'h8800 + 16'(i));
        end
        bus.clear_bank = 8'd9;
        bus.clear_req  = 1'b1;
        @(negedge clock);
        check("busy_cycle0", bus.clear_busy, 1'b0);
        tick();
        bus.clear_req = 1'b0;
        n_busy = 0;
        done_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (bus.clear_busy) n_busy++;
            if (bus.clear_done && done_cyc == 0) done_cyc = c;
        end
        tick();
        check("busy_cycles", n_busy, 8);
        check("done_cycle", done_cyc, 9);
        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("b9_clr_r%0d", i), 8'd9, 4'(i), 16'h0000);
            rd_chk($sformatf("b8_keep_r%0d", i), 8'd8, 4'(i), 16'h8800 + 16'(i));
        end

        // Write conflict during clear.
        bus.clear_bank = 8'd9;
        bus.clear_req  = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        tick();
        bus.bank_sel   = 8'd9;
        bus.write_addr = 4'h2;
        bus.write_data = 16'h7777;
        bus.write_en   = 1'b1;
        @(negedge clock);
        check("stall_ready", bus.write_ready, 1'b0);
        tick();
        bus.write_addr = 4'h9;
        bus.write_data = 16'h0999;
        @(negedge clock);
        check("scr_ready", bus.write_ready, 1'b1);
        tick();
        bus.write_addr = 4'h2;
        bus.write_data = 16'h7777;
        got = 1'b0;
        waits = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock);
            if (bus.write_ready) got = 1'b1;
            else begin
                waits++;
                tick();
            end
        end
        check("stall_released", got, 1'b1);
        check("stall_wait", waits, 5);
        tick();
        bus.write_en = 1'b0;
        rd_chk("b9_r2_new", 8'd9, 4'h2, 16'h7777);
        rd_chk("scr9_par", 8'd9, 4'h9, 16'h0999);
        rd_chk("b9_r3_zero", 8'd9, 4'h3, 16'h0000);

        // Reset in the middle of a clear.
        for (int i = 0; i < 8; i++) wr(8'd9, 4'(i), 16'hA5A0 + 16'(i));
        bus.read_addr  = {4'hA, 4'h9, 4'h8};
        bus.clear_bank = 8'd9;
        bus.clear_req  = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.clear_busy, 1'b0);
        check("mid_rst_ready", bus.write_ready, 1'b1);
        check("mid_rst_scr9", rdp(1), 16'h0000);
        bus.read_addr = {4'hD, 4'hC, 4'hB};
        #1;
        check("mid_rst_isr", rdp(1), 16'h0000);
        n_done = 0;
        repeat (2) begin
            @(negedge clock);
            if (bus.clear_done) n_done++;
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (bus.clear_done) n_done++;
        end
        tick();
        check("no_done_after_rst", n_done, 0);
        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("b9_part_r%0d", i), 8'd9, 4'(i),
                   (i < 4) ? 16'h0000 : 16'hA5A0 + 16'(i));
        end

        // Same-cycle read of a register being written.
        bus.read_addr  = {4'hC, 4'hA, 4'hB};
        bus.bank_sel   = 8'd0;
        bus.write_addr = 4'hA;
        bus.write_data = 16'h00FF;
        bus.write_en   = 1'b1;
        @(negedge clock);
`ifdef REGFILE_BYPASS_EN
        check("byp_same_cycle", rdp(1), 16'h00FF);
`else
        check("byp_same_cycle", rdp(1), 16'h0000);
`endif
        tick();
        bus.write_en = 1'b0;
        @(negedge clock);
        check("byp_next_cycle", rdp(1), 16'h00FF);
        tick();

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
